// File: rtl/om_range_ctrl.sv
// Range-tracking controller: arbitrates range registrations against address checks
// and drives the write, lookup and clear ports of an external range buffer.
module om_range_ctrl #(
  parameter int unsigned SIZE         = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [31:0]           alloc_first_i,
  input  logic [31:0]           alloc_last_i,
  output logic                  alloc_err_o,
  input  logic                  check_valid_i,
  output logic                  check_ready_o,
  input  logic [31:0]           check_addr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  resp_hit_o,
  output logic                  buf_en_write_o,
  output logic [31:0]           buf_first_o,
  output logic [31:0]           buf_last_o,
  output logic                  buf_find_o,
  output logic [31:0]           buf_find_addr_o,
  input  logic                  buf_hit_i,
  output logic                  buf_clr_o,
  output logic [$clog2(SIZE):0] count_o,
  output logic                  full_o,
  output logic                  overwrite_o,
  output logic [1:0]            state_o
);

  localparam int unsigned CW = $clog2(SIZE) + 1;
  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = SIZE[CW-1:0];
  localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT[SW-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     first_q, first_d;
  logic [31:0]     last_q, last_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            hit_q, hit_d;
  logic            grant_check;
  logic            grant_alloc;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // readies are only offered in IDLE, and valid may depend on nothing from this block.
  assign grant_check = check_valid_i && !((starve_q == STARVE_MAX) && alloc_valid_i);
  assign grant_alloc = alloc_valid_i && !grant_check;

  always_comb begin
    state_d        = state_q;
    first_d        = first_q;
    last_d         = last_q;
    addr_d         = addr_q;
    count_d        = count_q;
    starve_d       = starve_q;
    hit_d          = hit_q;
    alloc_ready_o  = 1'b0;
    check_ready_o  = 1'b0;
    buf_en_write_o = 1'b0;
    buf_find_o     = 1'b0;
    alloc_err_o    = 1'b0;
    overwrite_o    = 1'b0;
    buf_clr_o      = flush_i;

    if (flush_i) begin
      state_d  = IDLE;
      count_d  = '0;
      starve_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          check_ready_o = grant_check;
          alloc_ready_o = grant_alloc;
          if (!alloc_valid_i) starve_d = '0;
          if (grant_check) begin
            addr_d  = check_addr_i;
            state_d = CHECK;
            if (alloc_valid_i && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
          end else if (grant_alloc) begin
            first_d  = alloc_first_i;
            last_d   = alloc_last_i;
            starve_d = '0;
            state_d  = WRITE;
          end
        end
        WRITE: begin
          // When full the buffer replaces its oldest entry; the count stays at SIZE.
          if (first_q <= last_q) begin
            buf_en_write_o = 1'b1;
            overwrite_o    = full_o;
            if (!full_o) count_d = count_q + 1'b1;
          end else begin
            alloc_err_o = 1'b1;
          end
          state_d = IDLE;
        end
        CHECK: begin
          buf_find_o = 1'b1;
          hit_d      = buf_hit_i;
          state_d    = RESP;
        end
        RESP: begin
          if (resp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      first_q  <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      hit_q    <= hit_d;
    end
  end

  assign resp_valid_o    = (state_q == RESP);
  assign resp_hit_o      = hit_q;
  assign buf_first_o     = first_q;
  assign buf_last_o      = last_q;
  assign buf_find_addr_o = addr_q;
  assign count_o         = count_q;
  assign full_o          = (count_q == FULL_CNT);
  assign state_o         = state_q;

endmodule

// File: tb/tb_om_range_ctrl.sv
// Bench for om_range_ctrl: directed and randomised range registrations and address
// checks, with write and response expectations held in scoreboard queues.
module tb_om_range_ctrl;

  localparam int SIZE = 8;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        alloc_valid_i, alloc_ready_o;
  logic [31:0] alloc_first_i, alloc_last_i;
  logic        alloc_err_o;
  logic        check_valid_i, check_ready_o;
  logic [31:0] check_addr_i;
  logic        resp_valid_o, resp_ready_i, resp_hit_o;
  logic        buf_en_write_o;
  logic [31:0] buf_first_o, buf_last_o;
  logic        buf_find_o;
  logic [31:0] buf_find_addr_o;
  logic        buf_hit_i;
  logic        buf_clr_o;
  logic [3:0]  count_o;
  logic        full_o, overwrite_o;
  logic [1:0]  state_o;

  logic        hit_drv;
  int          n_cmp, n_err, exp_count;
  logic [65:0] exp_wr_q[$];
  logic [0:0]  exp_resp_q[$];
  logic [0:0]  exp_grant_q[$];
  logic [65:0] mon_e;
  logic [0:0]  mon_h;

  assign buf_hit_i = hit_drv;

  om_range_ctrl #(.SIZE(SIZE), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_first_i(alloc_first_i), .alloc_last_i(alloc_last_i),
    .alloc_err_o(alloc_err_o),
    .check_valid_i(check_valid_i), .check_ready_o(check_ready_o),
    .check_addr_i(check_addr_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_hit_o(resp_hit_o),
    .buf_en_write_o(buf_en_write_o), .buf_first_o(buf_first_o), .buf_last_o(buf_last_o),
    .buf_find_o(buf_find_o), .buf_find_addr_o(buf_find_addr_o),
    .buf_hit_i(buf_hit_i), .buf_clr_o(buf_clr_o),
    .count_o(count_o), .full_o(full_o), .overwrite_o(overwrite_o), .state_o(state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (buf_en_write_o || alloc_err_o || overwrite_o) begin
        if (exp_wr_q.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = exp_wr_q.pop_front();
          chk("wr_en", {63'd0, buf_en_write_o}, {63'd0, !mon_e[64]});
          chk("wr_err", {63'd0, alloc_err_o}, {63'd0, mon_e[64]});
          chk("wr_ovf", {63'd0, overwrite_o}, {63'd0, mon_e[65]});
          if (!mon_e[64]) begin
            chk("wr_first", {32'd0, buf_first_o}, {32'd0, mon_e[63:32]});
            chk("wr_last", {32'd0, buf_last_o}, {32'd0, mon_e[31:0]});
          end
        end
      end
      if (resp_valid_o && resp_ready_i) begin
        if (exp_resp_q.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_h = exp_resp_q.pop_front();
          chk("resp_hit_sb", {63'd0, resp_hit_o}, {63'd0, mon_h});
        end
      end
    end
  end

  // driver tasks
  task automatic do_alloc(input logic [31:0] f, input logic [31:0] l);
    int   n;
    logic err;
    @(posedge clk); #1;
    alloc_first_i = f; alloc_last_i = l; alloc_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!alloc_ready_o && n < 20) begin n++; @(negedge clk); end
    chk("alloc_ready", {63'd0, alloc_ready_o}, 64'd1);
    err = (f > l);
    exp_wr_q.push_back({(!err && exp_count == SIZE), err, f, l});
    if (!err && exp_count < SIZE) exp_count++;
    @(posedge clk); #1 alloc_valid_i = 1'b0;
    @(negedge clk);
    chk("alloc_lat", {63'd0, buf_en_write_o | alloc_err_o}, 64'd1);
    @(negedge clk);
    chk("count", {60'd0, count_o}, exp_count);
    chk("full", {63'd0, full_o}, {63'd0, exp_count == SIZE});
  endtask

  task automatic start_check(input logic [31:0] a, input logic h);
    int n;
    @(posedge clk); #1;
    check_addr_i = a; check_valid_i = 1'b1; hit_drv = h;
    n = 0;
    @(negedge clk);
    while (!check_ready_o && n < 20) begin n++; @(negedge clk); end
    chk("check_ready", {63'd0, check_ready_o}, 64'd1);
    exp_resp_q.push_back(h);
    @(posedge clk); #1 check_valid_i = 1'b0;
    @(negedge clk);
    chk("find", {63'd0, buf_find_o}, 64'd1);
    chk("find_addr", {32'd0, buf_find_addr_o}, {32'd0, a});
    chk("resp_early", {63'd0, resp_valid_o}, 64'd0);
    @(negedge clk);
    chk("resp_lat", {63'd0, resp_valid_o}, 64'd1);
    chk("resp_hit", {63'd0, resp_hit_o}, {63'd0, h});
  endtask

  task automatic finish_resp(input int delay, input logic h);
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      chk("resp_hold", {63'd0, resp_valid_o}, 64'd1);
      chk("hit_hold", {63'd0, resp_hit_o}, {63'd0, h});
    end
    @(posedge clk); #1 resp_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 resp_ready_i = 1'b0;
    @(negedge clk);
    chk("resp_done", {63'd0, resp_valid_o}, 64'd0);
  endtask

  task automatic do_flush(input logic with_alloc);
    @(posedge clk); #1;
    flush_i = 1'b1;
    if (with_alloc) begin
      alloc_valid_i = 1'b1; alloc_first_i = 32'h5000; alloc_last_i = 32'h5FFF;
    end
    @(negedge clk);
    chk("flush_clr", {63'd0, buf_clr_o}, 64'd1);
    chk("flush_ardy", {63'd0, alloc_ready_o}, 64'd0);
    chk("flush_crdy", {63'd0, check_ready_o}, 64'd0);
    @(posedge clk); #1 flush_i = 1'b0; alloc_valid_i = 1'b0;
    exp_count = 0;
    @(negedge clk);
    chk("flush_count", {60'd0, count_o}, 64'd0);
    chk("flush_state", {62'd0, state_o}, 64'd0);
    chk("flush_clr_end", {63'd0, buf_clr_o}, 64'd0);
  endtask

  initial begin
    int          n;
    logic [0:0]  g;
    logic [31:0] f, l;
    n_cmp = 0; n_err = 0; exp_count = 0;
    rst_n = 1'b0; flush_i = 1'b0;
    alloc_valid_i = 1'b0; alloc_first_i = '0; alloc_last_i = '0;
    check_valid_i = 1'b0; check_addr_i = '0;
    resp_ready_i = 1'b0; hit_drv = 1'b0;

    #3;
    chk("rst_state", {62'd0, state_o}, 64'd0);
    chk("rst_count", {60'd0, count_o}, 64'd0);
    chk("rst_full", {63'd0, full_o}, 64'd0);
    chk("rst_resp", {63'd0, resp_valid_o | resp_hit_o}, 64'd0);
    chk("rst_bufs", {buf_first_o, buf_last_o}, 64'd0);
    chk("rst_strobes", {60'd0, buf_en_write_o, buf_find_o, buf_clr_o, alloc_err_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic registration, rejected range, hit/miss checks
    do_alloc(32'h1000, 32'h10FF);
    do_alloc(32'h2000, 32'h1FFF);
    start_check(32'h1080, 1'b1);
    finish_resp(3, 1'b1);
    start_check(32'h3000, 1'b0);
    finish_resp(1, 1'b0);

    // flush with a competing alloc, then nine allocs to saturate
    do_flush(1'b1);
    for (int i = 0; i < 9; i++) begin
      f = $urandom_range(0, 32'h7FFF_FFFF);
      l = f + $urandom_range(0, 255);
      do_alloc(f, l);
    end
    chk("sat_count", {60'd0, count_o}, 64'd8);

    // flush while a response is pending, count 5
    do_flush(1'b0);
    for (int i = 0; i < 5; i++) do_alloc(32'h100 * i, 32'h100 * i + 32'h40);
    start_check(32'h1080, 1'b1);
    @(posedge clk); #1 flush_i = 1'b1;
    @(negedge clk);
    chk("rflush_clr", {63'd0, buf_clr_o}, 64'd1);
    chk("rflush_find", {63'd0, buf_find_o | buf_en_write_o}, 64'd0);
    @(posedge clk); #1 flush_i = 1'b0;
    void'(exp_resp_q.pop_back());
    exp_count = 0;
    @(negedge clk);
    chk("rflush_resp", {63'd0, resp_valid_o}, 64'd0);
    chk("rflush_count", {60'd0, count_o}, 64'd0);
    chk("rflush_state", {62'd0, state_o}, 64'd0);

    // arbitration with both requesters always valid
    for (int k = 0; k < 2; k++) begin
      repeat (4) exp_grant_q.push_back(1'b0);
      exp_grant_q.push_back(1'b1);
    end
    @(posedge clk); #1;
    hit_drv = 1'b0; resp_ready_i = 1'b1;
    check_valid_i = 1'b1; check_addr_i = 32'h44;
    alloc_valid_i = 1'b1; alloc_first_i = 32'h10; alloc_last_i = 32'h20;
    n = 0;
    while (exp_grant_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (check_ready_o || alloc_ready_o) begin
        g = exp_grant_q.pop_front();
        chk("arb_grant", {63'd0, alloc_ready_o}, {63'd0, g});
        if (alloc_ready_o) begin
          exp_wr_q.push_back({(exp_count == SIZE), 1'b0, 32'h10, 32'h20});
          if (exp_count < SIZE) exp_count++;
        end else begin
          exp_resp_q.push_back(1'b0);
        end
      end
    end
    chk("arb_done", exp_grant_q.size(), 64'd0);
    @(posedge clk); #1 check_valid_i = 1'b0; alloc_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("arb_count", {60'd0, count_o}, exp_count);
    @(posedge clk); #1 resp_ready_i = 1'b0;

    // asynchronous reset while a response is pending
    start_check(32'h2222, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp", {63'd0, resp_valid_o}, 64'd0);
    chk("arst_state", {62'd0, state_o}, 64'd0);
    chk("arst_count", {60'd0, count_o}, 64'd0);
    chk("arst_addr", {32'd0, buf_find_addr_o}, 64'd0);
    void'(exp_resp_q.pop_back());
    exp_count = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_noreplay", {62'd0, resp_valid_o, buf_en_write_o}, 64'd0);
    do_alloc(32'h8000, 32'h8000);

    repeat (2) @(negedge clk);
    chk("wr_q_empty", exp_wr_q.size(), 64'd0);
    chk("resp_q_empty", exp_resp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
